// File: rtl/ring_reader_pkg.sv
// Shared types for the ring reader: a lap-tagged buffer pointer and its
// wrapping increment.
package ring_reader_pkg;

    localparam int unsigned PTR_ADDR_W = 8;

    typedef struct packed {
        logic                  lap;
        logic [PTR_ADDR_W-1:0] addr;
    } ptr_t;

    // Advance a pointer; wrapping past max_val flips the lap bit.
    function automatic ptr_t ptr_next(input ptr_t p, input logic [PTR_ADDR_W-1:0] max_val);
        ptr_t n;
        if (p.addr == max_val) begin
            n.addr = '0;
            n.lap  = ~p.lap;
        end else begin
            n.addr = p.addr + PTR_ADDR_W'(1);
            n.lap  = p.lap;
        end
        return n;
    endfunction

endpackage

// File: rtl/ring_reader_counter.sv
// Wrapping up/down counter (0..MAX_VAL_P) with synchronous active-low load
// of a reset value; holds the ring reader's address.
module ring_reader_counter #(
    parameter int unsigned WIDTH_P   = 8,
    parameter int unsigned MAX_VAL_P = 128
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [WIDTH_P-1:0] rstn_data_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic               en_i,
    output logic [WIDTH_P-1:0] count_o
);

    logic [WIDTH_P-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && up_i && !down_i) begin
            count_d = (count_q == WIDTH_P'(MAX_VAL_P)) ? '0 : count_q + WIDTH_P'(1);
        end else if (en_i && down_i && !up_i) begin
            count_d = (count_q == '0) ? WIDTH_P'(MAX_VAL_P) : count_q - WIDTH_P'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) count_q <= rstn_data_i;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/ring_reader.sv
// Read side of a circular pixel buffer: issues 1-cycle-latency reads and
// streams words in order through a 2-entry skid buffer. Optional level_o
// output under RING_READER_LEVEL_EN.
module ring_reader
    import ring_reader_pkg::*;
#(
    parameter int unsigned WIDTH_P      = 8,
    parameter int unsigned MAX_VAL_P    = 128,
    parameter int unsigned DATA_WIDTH_P = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH_P-1:0]      wr_ptr_i,
    input  logic                    wr_lap_i,
    output logic                    mem_rd_en_o,
    output logic [WIDTH_P-1:0]      mem_rd_addr_o,
    input  logic [DATA_WIDTH_P-1:0] mem_rd_data_i,
    output logic                    valid_o,
    output logic [DATA_WIDTH_P-1:0] data_o,
    input  logic                    ready_i,
    output logic                    empty_o,
    output logic                    full_o
`ifdef RING_READER_LEVEL_EN
    ,
    output logic [WIDTH_P:0]        level_o
`endif
);

    logic [WIDTH_P-1:0]      rd_ptr;
    logic                    rd_lap_q, rd_lap_d;
    logic                    inflight_q;
    logic                    valid_q, valid_d;
    logic [1:0]              buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH_P-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic                    issue, pop, empty_c, full_c;
    ptr_t                    rd_cur, rd_nxt;
    logic                    unused_nxt_addr;

    assign empty_c = (rd_ptr == wr_ptr_i) && (rd_lap_q == wr_lap_i);
    assign full_c  = (rd_ptr == wr_ptr_i) && (rd_lap_q != wr_lap_i);
    assign pop     = valid_q && ready_i;

    // Issue only while buffered + in-flight words, net of this cycle's pop, leave room.
    assign issue = !rst_i && !empty_c &&
                   ((3'(buf_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    ring_reader_counter #(
        .WIDTH_P   (WIDTH_P),
        .MAX_VAL_P (MAX_VAL_P)
    ) u_rd_ptr (
        .clk_i       (clk_i),
        .rstn_i      (~rst_i),
        .rstn_data_i ({WIDTH_P{1'b0}}),
        .up_i        (issue),
        .down_i      (1'b0),
        .en_i        (1'b1),
        .count_o     (rd_ptr)
    );

    // Lap follows the counter's wrap; the address half comes from the counter itself.
    always_comb begin
        rd_cur.lap  = rd_lap_q;
        rd_cur.addr = PTR_ADDR_W'(rd_ptr);
        rd_nxt      = ptr_next(rd_cur, PTR_ADDR_W'(MAX_VAL_P));
        rd_lap_d    = issue ? rd_nxt.lap : rd_lap_q;
    end

    assign unused_nxt_addr = ^rd_nxt.addr;

    // Skid buffer: pop shifts the tail forward, then capture lands behind what remains.
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) buf0_d = mem_rd_data_i;
            else                   buf1_d = mem_rd_data_i;
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
        valid_d = (buf_cnt_d != 2'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_lap_q   <= 1'b0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rd_lap_q   <= rd_lap_d;
            inflight_q <= issue;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_rd_en_o   = issue;
    assign mem_rd_addr_o = rd_ptr;
    assign valid_o       = valid_q;
    assign data_o        = buf0_q;
    assign empty_o       = empty_c;
    assign full_o        = full_c;

`ifdef RING_READER_LEVEL_EN
    localparam int unsigned LVL_W = WIDTH_P + 1;

    logic [WIDTH_P:0] level_q, level_d;

    always_comb begin
        level_d = LVL_W'(wr_ptr_i) - LVL_W'(rd_ptr);
        if (rd_lap_q != wr_lap_i) begin
            level_d = LVL_W'(MAX_VAL_P + 1) - LVL_W'(rd_ptr) + LVL_W'(wr_ptr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) level_q <= '0;
        else       level_q <= level_d;
    end

    assign level_o = level_q;
`endif

endmodule
